vscale_hasti_sram_ctrl: RTL
===========================

VSCALE_HASTI_SRAM_CTRL -- requirements
Module: vscale_hasti_sram_ctrl

Interface
REQ-001 SHALL provide parameter NWORDS, default 32, number of 32-bit words in the array.
REQ-002 SHALL provide parameter WAIT_STATES, default 0, legal range 0..3, number of hready-low cycles inserted in each OKAY data phase.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port haddr, input, 32, byte address of the address phase.
REQ-006 SHALL have ports hwrite (input, 1), hsize (input, 3), hburst (input, 3), hmastlock (input, 1), hprot (input, 4), htrans (input, 2), with HASTI meanings; hburst, hmastlock and hprot are ignored.
REQ-007 SHALL have port hwdata, input, 32, write data, sampled in the data phase.
REQ-008 SHALL have port hrdata, output, 32, read data.
REQ-009 SHALL have ports hready (output, 1) and hresp (output, 1), where hresp 0 means OKAY and 1 means ERROR.
REQ-010 SHALL have port err_count, output, 8, saturating count of ERROR responses.

Function
REQ-011 SHALL accept a transfer in any cycle where hready=1 and htrans is NONSEQ (2'b10) or SEQ (2'b11), registering addr, write, size and lane info.
REQ-012 SHALL give IDLE/BUSY transfers a zero-wait OKAY response (hready=1, hresp=0) with no array access.
REQ-013 SHALL implement states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-014 On an accepted legal transfer, SHALL go to WAIT when WAIT_STATES>0 (otherwise directly to DATA), drive hready=0 for exactly WAIT_STATES cycles, then spend 1 cycle in DATA with hready=1 and hresp=0.
REQ-015 SHALL treat as illegal any of: word index haddr[31:2] >= NWORDS; hsize > 3'b010; hsize=halfword with haddr[0]=1; hsize=word with haddr[1:0]!=0.
REQ-016 On an illegal transfer, SHALL drive ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), perform no array access, and ignore WAIT_STATES.
REQ-017 On an illegal transfer, SHALL increment err_count on entry to ERR2, saturating at 8'hFF.
REQ-018 For writes, SHALL sample hwdata in the DATA cycle and commit at the edge ending DATA.
REQ-019 Write byte enables SHALL be: byte -> lane haddr[1:0]; halfword -> lanes {haddr[1],0} and {haddr[1],1}; word -> all lanes; unselected bytes unchanged.
REQ-020 For reads, hrdata SHALL carry the full addressed 32-bit word during the DATA cycle; lane extraction is the master's job.
REQ-021 hrdata SHALL be a register loaded at the edge entering DATA and holding its value at all other times.
REQ-022 Forwarding: SHALL merge the write's enabled bytes into the loaded read word when a write DATA cycle coincides with the edge loading a read to the same word index.
REQ-023 A new transfer presented in the DATA or ERR2 cycle SHALL be accepted (pipelined), giving back-to-back throughput of 1 transfer per (1+WAIT_STATES) cycles.
REQ-024 SHALL ignore htrans in the WAIT and ERR1 states (hready=0) and latch no new address phase there.
REQ-025 SHALL ignore haddr bits above the word index range only via REQ-015; there SHALL be no aliasing.

Reset
REQ-026 While reset=1 at a clock edge, SHALL enter IDLE with hready=1, hresp=0, hrdata=32'h0 and err_count=8'h0.
REQ-027 Reset SHALL discard any in-flight transfer; a write not yet past its DATA edge is not committed.
REQ-028 Reset SHALL not clear array contents.
REQ-029 In the first cycle after reset deasserts, SHALL be able to accept a transfer.

Verification
REQ-030 WAIT_STATES=0, word write 32'hDEADBEEF to 0x8 then word read 0x8 back-to-back -> read DATA cycle hrdata=32'hDEADBEEF via forwarding, hready=1 every cycle.
REQ-031 WAIT_STATES=2, byte write 8'h5A to 0x13 over word 32'h11223344 at 0x10, then word read 0x10 -> each DATA preceded by 2 hready-low cycles, read returns 32'h5A223344.
REQ-032 Read of 0x80 with NWORDS=32 -> ERR1 (hready=0, hresp=1), ERR2 (hready=1, hresp=1), err_count 0->1, array unchanged.
REQ-033 Halfword write to 0x1 -> ERROR response; 256 further illegal accesses -> err_count saturates at 8'hFF.
REQ-034 Reset asserted during the WAIT of a word write 32'hCAFEF00D to 0x4 (old value 32'h0) -> next cycle hready=1, hresp=0, hrdata=0, and a read of 0x4 returns 32'h0.
REQ-035 IDLE then BUSY htrans with random haddr -> hready=1, hresp=0, no array change, err_count unchanged.

Source files
------------

// File: rtl/vscale_hasti_sram_ctrl.sv
// vscale_hasti_sram_ctrl: HASTI slave in front of a word-organised SRAM array.
// Each legal transfer gets a fixed number of wait states before its data
// cycle. Illegal transfers get a two-cycle ERROR response and are counted.
// Read data is registered. A write whose data cycle overlaps the load of a
// read to the same word is forwarded into that read.
module vscale_hasti_sram_ctrl #(
  parameter int NWORDS      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic [7:0]  err_count
);

  localparam int          IDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] NWORDS_W  = 32'(NWORDS);
  localparam logic [1:0]  WAIT_LAST = 2'(WAIT_STATES - 1);
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      mem_r [NWORDS];
  logic [IDX_W-1:0] idx_r;
  logic             write_r;
  logic [3:0]       be_r;
  logic [1:0]       wait_cnt_r;
  logic [31:0]      hrdata_r;
  logic [7:0]       err_count_r;

  logic             hready_s;
  logic             hresp_s;
  logic             accept_s;
  logic             illegal_s;
  logic [IDX_W-1:0] haddr_idx_s;
  logic             commit_s;
  logic             load_s;
  logic [IDX_W-1:0] load_idx_s;
  logic             fwd_s;
  logic [31:0]      load_word_s;

  // Inputs the slave has no use for: burst type, lock, protection and the SEQ/NONSEQ bit.
  logic unused_s;
  assign unused_s = ^{hburst, hmastlock, hprot, htrans[0]};

  // Byte lanes touched by a transfer of the given size at the given low address bits.
  function automatic logic [3:0] byte_en_f(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replace the enabled bytes of old_w with the matching bytes of new_w.
  function automatic logic [31:0] merge_f(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return m;
  endfunction

  assign haddr_idx_s = haddr[IDX_W+1:2];
  assign hrdata      = hrdata_r;
  assign hready      = hready_s;
  assign hresp       = hresp_s;
  assign err_count   = err_count_r;

  // Address-phase decode: is a transfer accepted this cycle, and is it illegal.
  always_comb begin
    accept_s  = hready_s && htrans[1];
    illegal_s = 1'b0;
    if ({2'b00, haddr[31:2]} >= NWORDS_W) begin
      illegal_s = 1'b1;
    end else if (hsize > 3'b010) begin
      illegal_s = 1'b1;
    end else if ((hsize == 3'b001) && haddr[0]) begin
      illegal_s = 1'b1;
    end else if ((hsize == 3'b010) && (haddr[1:0] != 2'b00)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: new transfers are accepted only in cycles with hready high.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (illegal_s) begin
          state_nxt_s = ST_ERR1;
        end else if (HAS_WAIT) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: stall in WAIT and ERR1, flag ERROR in both error cycles.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = 1'b0;
    case (state_r)
      ST_WAIT: begin
        hready_s = 1'b0;
        hresp_s  = 1'b0;
      end
      ST_ERR1: begin
        hready_s = 1'b0;
        hresp_s  = 1'b1;
      end
      ST_ERR2: begin
        hready_s = 1'b1;
        hresp_s  = 1'b1;
      end
      default: begin
        hready_s = 1'b1;
        hresp_s  = 1'b0;
      end
    endcase
  end

  // Capture the address phase of every accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r   <= {IDX_W{1'b0}};
      write_r <= 1'b0;
      be_r    <= 4'b0000;
    end else if (accept_s) begin
      idx_r   <= haddr_idx_s;
      write_r <= hwrite;
      be_r    <= byte_en_f(hsize, haddr[1:0]);
    end
  end

  // Wait-state counter: restarts on accept, advances while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 2'b00;
    end else if (accept_s) begin
      wait_cnt_r <= 2'b00;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 2'b01;
    end
  end

  // Write commit at the edge ending a write's data cycle; reset cancels it.
  assign commit_s = (state_r == ST_DATA) && write_r && !reset;

  // Write the enabled bytes into the array. The array itself is never cleared.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[idx_r] <= merge_f(mem_r[idx_r], hwdata, be_r);
    end
  end

  // Read-load select: which word enters hrdata on the edge into DATA, with forwarding.
  always_comb begin
    load_s     = 1'b0;
    load_idx_s = idx_r;
    if (state_nxt_s == ST_DATA) begin
      if (state_r == ST_WAIT) begin
        load_s     = !write_r;
        load_idx_s = idx_r;
      end else begin
        load_s     = !hwrite;
        load_idx_s = haddr_idx_s;
      end
    end else begin
      load_s     = 1'b0;
      load_idx_s = idx_r;
    end
    fwd_s       = commit_s && (idx_r == load_idx_s);
    load_word_s = fwd_s ? merge_f(mem_r[load_idx_s], hwdata, be_r) : mem_r[load_idx_s];
  end

  // Read data register: loads on entry to a read data cycle, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      hrdata_r <= 32'h0000_0000;
    end else if (load_s) begin
      hrdata_r <= load_word_s;
    end
  end

  // Saturating ERROR counter, stepped as the FSM moves from ERR1 to ERR2.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= 8'h00;
    end else if ((state_r == ST_ERR1) && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'h01;
    end
  end

endmodule
